// File: rtl/led_fader.sv
// led_fader: per-LED PWM afterglow for the active-low LED chaser.
// Requested LEDs are held at full brightness, released ones fade linearly.
module led_fader #(
   parameter int PWM_BITS   = 8,
   parameter int DECAY_DIV  = 16,
   parameter int DECAY_STEP = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pattern_n,
   output logic [7:0] leds,
   output logic       decay_tick
);

   localparam logic [PWM_BITS-1:0] MAX  = '1;
   localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

   logic [7:0]                s1;
   logic [7:0]                s2;
   logic [DECAY_DIV-1:0]      div_ctr;
   logic [PWM_BITS-1:0]       pwm_ctr;
   logic [7:0][PWM_BITS-1:0]  level;
   logic [7:0][PWM_BITS-1:0]  level_nxt;
   logic [7:0]                lit;

   // pattern_n is asynchronous to clk
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 8'hFF;
         s2 <= 8'hFF;
      end else begin
         s1 <= pattern_n;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_ctr    <= '0;
         decay_tick <= 1'b0;
         pwm_ctr    <= '0;
      end else begin
         div_ctr    <= div_ctr + 1'b1;
         decay_tick <= &div_ctr;
         pwm_ctr    <= pwm_ctr + 1'b1;
      end
   end

   always_comb begin
      level_nxt = level;
      lit       = '0;
      for (int i = 0; i < 8; i++) begin
         if (!s2[i]) begin
            level_nxt[i] = MAX;
         end else if (decay_tick) begin
            level_nxt[i] = (level[i] > STEP) ? level[i] - STEP : '0;
         end
         // full scale must not blink off when pwm_ctr reaches MAX
         lit[i] = (level[i] == MAX) | (level[i] > pwm_ctr);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level <= '0;
         leds  <= 8'hFF;
      end else begin
         level <= level_nxt;
         leds  <= ~lit;
      end
   end

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed checks of sync latency, decay, PWM duty,
// request/tick collision, chaser trail and reset behaviour.
module tb_led_fader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pattern_n;
   logic [7:0] leds;
   logic       decay_tick;

   int total = 0;
   int bad   = 0;
   int cnt[8];

   led_fader #(
      .PWM_BITS(8),
      .DECAY_DIV(10),
      .DECAY_STEP(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pattern_n(pattern_n),
      .leds(leds),
      .decay_tick(decay_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_tick(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!decay_tick && n < 2100);
      check(tag, 32'(decay_tick), 1);
   endtask

   // sample 256 consecutive cycles, count lit cycles per LED
   task automatic measure();
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      for (int c = 0; c < 256; c++) begin
         for (int i = 0; i < 8; i++)
            if (!leds[i]) cnt[i]++;
         @(negedge clk);
      end
   endtask

   int decay_exp[5] = '{191, 127, 63, 0, 0};
   int trail_exp[4] = '{256, 191, 127, 63};

   initial begin
      int n;
      int errs;
      int gap;
      int d;
      int e;
      logic [7:0] p;

      // reset held 3 edges with every LED requested
      rst = 1'b1;
      pattern_n = 8'h00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_leds", 32'(leds), 32'hFF);
         check("rst_tick", 32'(decay_tick), 0);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rel_edge3", 32'(leds), 32'hFF);
      @(negedge clk);
      check("rel_edge4", 32'(leds), 32'h00);

      // solid on, across several PWM wraps
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pattern_n = 8'hFE;
      repeat (4) @(negedge clk);
      errs = 0;
      for (int c = 0; c < 600; c++) begin
         if (leds !== 8'hFE) errs++;
         @(negedge clk);
      end
      check("solid_on", 32'(errs), 0);
      check("solid_lvl", 32'(dut.level[0]), 255);

      // tick period
      wait_tick("per_sync");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!decay_tick && n < 2000);
      check("tick_period", 32'(n), 1024);

      // linear decay, released right after a tick
      pattern_n = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         wait_tick("dec_tick");
         @(negedge clk);
         check("dec_level", 32'(dut.level[0]), 32'(decay_exp[k]));
         @(negedge clk);
         measure();
         check("dec_lit", 32'(cnt[0]), 32'(decay_exp[k]));
      end

      // collision: request reaches s2 on the tick cycle at level 127
      pattern_n = 8'hFE;
      repeat (8) @(negedge clk);
      wait_tick("col_t0");
      pattern_n = 8'hFF;
      wait_tick("col_t1");
      wait_tick("col_t2");
      repeat (1022) @(negedge clk);
      check("col_pre", 32'(dut.level[0]), 127);
      pattern_n = 8'hFE;
      repeat (2) @(negedge clk);
      check("col_tick", 32'(decay_tick), 1);
      check("col_s2", 32'(dut.s2[0]), 0);
      @(negedge clk);
      check("col_level", 32'(dut.level[0]), 255);
      @(negedge clk);
      measure();
      check("col_lit", 32'(cnt[0]), 256);

      // reset mid-fade
      wait_tick("mf_t0");
      pattern_n = 8'hFF;
      wait_tick("mf_t1");
      wait_tick("mf_t2");
      @(negedge clk);
      check("mf_pre", 32'(dut.level[0]), 127);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mf_leds", 32'(leds), 32'hFF);
      check("mf_level", 32'(dut.level[0]), 0);
      errs = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (leds !== 8'hFF) errs++;
      end
      check("mf_dark", 32'(errs), 0);

      // chaser trail, each step lands 3 cycles ahead of a tick
      wait_tick("ch_sync");
      gap = 1021;
      for (int b = 0; b < 8; b++) begin
         repeat (gap) @(negedge clk);
         p = 8'h01 << b;
         pattern_n = ~p;
         repeat (3) @(negedge clk);
         check("ch_tick", 32'(decay_tick), 1);
         repeat (2) @(negedge clk);
         measure();
         if (b == 2 || b == 7) begin
            for (int i = 0; i < 8; i++) begin
               d = b - i;
               e = (d >= 0 && d < 4) ? trail_exp[d] : 0;
               check($sformatf("ch_b%0d_led%0d", b, i), 32'(cnt[i]), 32'(e));
            end
         end
         gap = 1021 - 258;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_fader.md
# led_fader

Per-LED PWM afterglow stage that sits directly downstream of the sequential LED shifter and drives the board's eight active-low LEDs. It takes the shifter's active-low 8-bit pattern and synchronises it into the system clock domain. Any LED requested on is held at full brightness; once released it fades linearly to off, so the chaser leaves a decaying trail. All logic runs on the single system clock.

## Interface
Parameters:
- PWM_BITS, 8: width of each brightness level and of the PWM counter; MAX = 2^PWM_BITS-1
- DECAY_DIV, 16: decay tick period is 2^DECAY_DIV clocks
- DECAY_STEP, 8: brightness decrement per decay tick (1..MAX)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pattern_n  in  8  requested LED pattern, active-low (0 = LED requested on); may change asynchronously to clk
- leds  out  8  LED drive, active-low (0 = lit), registered
- decay_tick  out  1  one-cycle pulse on each decay step, registered (debug/bench visibility)

## Operation
- Input sync: two-flop synchroniser per bit, pattern_n -> s1 -> s2, reset value 8'hFF.
- Decay prescaler: div_ctr, DECAY_DIV bits, free-running, wraps. decay_tick = 1 for the one cycle after div_ctr == all-ones, i.e. once every 2^DECAY_DIV clocks.
- Brightness: level[i], PWM_BITS wide, one per LED. Each cycle, in priority order:
  - s2[i] == 0 -> level[i] <= MAX (request wins over a simultaneous tick)
  - else decay_tick -> level[i] <= (level[i] > DECAY_STEP) ? level[i] - DECAY_STEP : 0 (saturating, never wraps below 0)
  - else hold
- PWM: pwm_ctr, PWM_BITS wide, free-running 0..MAX, wraps to 0.
- Output: leds[i] <= ~((level[i] == MAX) | (level[i] > pwm_ctr)).
  - MAX -> solid on, no off cycle at wrap.
  - 0 -> solid off.
  - Otherwise exactly level[i] lit cycles per 2^PWM_BITS window.
- No state machine beyond the counters; all eight channels are independent and identical.
- Reset (synchronous): s1 = s2 = 8'hFF, level = 0, pwm_ctr = 0, div_ctr = 0, decay_tick = 0, leds = 8'hFF (all off).
- Reset mid-fade discards all brightness; channels restart dark and resume only on a new request.

## Timing
- Edge count starts at the first clk edge that samples a pattern_n bit low into s1 (edge 1).
- That bit reaches s2 at edge 2, level = MAX at edge 3, and leds[i] goes low at edge 4.
- Release latency matches (4 edges). The first decrement follows at the next decay_tick after s2[i] reads 1.
- Full fade from MAX to 0 takes ceil(MAX/DECAY_STEP) ticks; defaults give 32 ticks of 65536 clocks.
- Outputs change only on rising clk edges.
- While rst is high, leds = 8'hFF and decay_tick = 0 from the first edge with rst sampled high.
- Bench parameters for the test plan: PWM_BITS=8, DECAY_DIV=10, DECAY_STEP=64.

## Test plan
- Reset: pattern_n=8'h00, hold rst high for 3 edges -> leds=8'hFF and decay_tick=0 throughout. After release, leds=8'h00 by the 4th edge.
- Solid on: pattern_n=8'hFE steady -> leds[0]=0 on every cycle, including across pwm_ctr wrap 255->0. leds[7:1]=7'h7F constantly.
- Linear decay:
  - Drive pattern_n=8'hFE long enough to reach MAX, then 8'hFF.
  - On successive ticks level[0] = 191, 127, 63, then 0.
  - Lit-cycle count per 256-cycle PWM window inside each tick period is 191, 127, 63, then 0 thereafter.
  - decay_tick period is exactly 1024 clocks.
- Collision: with level[0]=127, assert pattern_n[0]=0 so s2[0]=0 on the decay_tick cycle -> level[0]=255, not 63. leds[0] becomes solid low.
- Chaser trail:
  - Walk a single 0 through pattern_n bits 0..7, one bit per 1024 clocks.
  - Currently requested LED is solid on.
  - The previous LED has 191 lit cycles per window, the one before 127, the one before that 63, and older LEDs are off.
- Reset mid-fade: with level[0]=127, pulse rst one cycle -> leds=8'hFF on the next edge and remains 8'hFF with pattern_n=8'hFF.
